// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory port between the CPU bus and a DMA port.
// One transaction per grant, fixed wait states, one-cycle ack per requester.
module mem_bus_arbiter #(
    parameter int unsigned ADDR_W      = 13,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              dma_req,
    input  logic              dma_wr,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
    logic              pick_dma;
    logic              in_acc;

    // DMA wins only when alone or when the CPU had the last grant
    assign pick_dma = dma_req & (~cpu_req | ~last_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        owner_d     = owner_q;
        last_d      = last_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (cpu_req | dma_req) begin
                    state_d = ACCESS;
                    cnt_d   = 4'(WAIT_CYCLES);
                    owner_d = pick_dma;
                    last_d  = pick_dma;
                    wr_d    = pick_dma ? dma_wr : cpu_wr;
                    addr_d  = pick_dma ? dma_addr : cpu_addr;
                    wdata_d = pick_dma ? dma_wdata : cpu_wdata;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    if (!wr_q) begin
                        if (owner_q) dma_rdata_d = mem_rdata;
                        else         cpu_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    // Strobes decode straight from the state flop so reset drops them at once
    assign in_acc    = (state_q == ACCESS);
    assign mem_rd    = in_acc & ~wr_q;
    assign mem_wr    = in_acc & wr_q;
    assign mem_addr  = in_acc ? addr_q : '0;
    assign mem_wdata = in_acc ? wdata_q : '0;
    assign cpu_ack   = (state_q == DONE) & ~owner_q;
    assign dma_ack   = (state_q == DONE) & owner_q;
    assign busy      = (state_q == ACCESS) | (state_q == DONE);
    assign owner     = owner_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a WAIT_CYCLES=1 instance and a
// WAIT_CYCLES=0 instance share the same stimulus.
module tb_mem_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic        cpu_req, cpu_wr, dma_req, dma_wr;
    logic [12:0] cpu_addr, dma_addr;
    logic [7:0]  cpu_wdata, dma_wdata, mem_rdata;

    logic [7:0]  cpu_rdata, dma_rdata, mem_wdata;
    logic        cpu_ack, dma_ack, mem_rd, mem_wr, owner, busy;
    logic [12:0] mem_addr;

    logic [7:0]  z_cpu_rdata, z_dma_rdata, z_mem_wdata;
    logic        z_cpu_ack, z_dma_ack, z_mem_rd, z_mem_wr, z_owner, z_busy;
    logic [12:0] z_mem_addr;

    int nvec = 0;
    int nerr = 0;

    mem_bus_arbiter #(.ADDR_W(13), .DATA_W(8), .WAIT_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .owner(owner), .busy(busy)
    );

    mem_bus_arbiter #(.ADDR_W(13), .DATA_W(8), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(z_cpu_rdata), .cpu_ack(z_cpu_ack),
        .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_rdata(z_dma_rdata), .dma_ack(z_dma_ack),
        .mem_addr(z_mem_addr), .mem_rd(z_mem_rd), .mem_wr(z_mem_wr),
        .mem_wdata(z_mem_wdata), .mem_rdata(mem_rdata),
        .owner(z_owner), .busy(z_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        assert (!(mem_rd && mem_wr) && !(z_mem_rd && z_mem_wr))
        else begin
            nerr++;
            $error("FAIL strobe_excl: rd/wr both high");
        end
        assert (!(cpu_ack && dma_ack) && !(z_cpu_ack && z_dma_ack))
        else begin
            nerr++;
            $error("FAIL ack_excl: both acks high");
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        cpu_req = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_wr = 0; dma_addr = '0; dma_wdata = '0;
        mem_rdata = '0;
        #1 rst_n = 1'b0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_strobes", {mem_rd, mem_wr}, 0);
        chk("rst_acks", {cpu_ack, dma_ack}, 0);
        chk("rst_owner", owner, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_rdata", {cpu_rdata, dma_rdata}, 0);
        rst_n = 1'b1;

        // 1: CPU read, WAIT=1
        mem_rdata = 8'h3C;
        cpu_req = 1; cpu_wr = 0; cpu_addr = 13'h0A5;
        tick();
        chk("t1_rd_c1", mem_rd, 1);
        chk("t1_addr", mem_addr, 13'h0A5);
        chk("t1_owner", owner, 0);
        chk("t1_busy", busy, 1);
        tick();
        chk("t1_rd_c2", mem_rd, 1);
        chk("t1_noack", cpu_ack, 0);
        tick();
        chk("t1_rd_off", mem_rd, 0);
        chk("t1_ack", cpu_ack, 1);
        chk("t1_rdata", cpu_rdata, 8'h3C);
        cpu_req = 0;
        tick();
        chk("t1_ack_off", cpu_ack, 0);
        chk("t1_idle", {busy, mem_addr}, 0);

        // 2: DMA write at top address
        mem_rdata = 8'h77;
        dma_req = 1; dma_wr = 1; dma_addr = 13'h1FFF; dma_wdata = 8'hA5;
        tick();
        chk("t2_wr_c1", {mem_wr, mem_rd}, 2'b10);
        chk("t2_addr", mem_addr, 13'h1FFF);
        chk("t2_wdata", mem_wdata, 8'hA5);
        chk("t2_owner", owner, 1);
        tick();
        chk("t2_wr_c2", mem_wr, 1);
        tick();
        chk("t2_wr_off", mem_wr, 0);
        chk("t2_acks", {dma_ack, cpu_ack}, 2'b10);
        chk("t2_rdata", dma_rdata, 8'h00);
        dma_req = 0; dma_wr = 0;
        tick();
        chk("t2_ack_off", dma_ack, 0);
        chk("t2_wdata0", mem_wdata, 0);

        // 3: both held, grants alternate
        mem_rdata = 8'h5A;
        cpu_addr = 13'h010; dma_addr = 13'h020;
        cpu_req = 1; dma_req = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3_owner", owner, i % 2);
            chk("t3_addr", mem_addr, (i % 2) ? 13'h020 : 13'h010);
            tick();
            tick();
            chk("t3_acks", {dma_ack, cpu_ack}, (i % 2) ? 2'b10 : 2'b01);
            tick();
            chk("t3_gap", busy, 0);
            if (i == 3) begin
                cpu_req = 0; dma_req = 0;
            end
        end
        chk("t3_crd", cpu_rdata, 8'h5A);
        chk("t3_drd", dma_rdata, 8'h5A);

        // 4: inputs changed mid-access
        mem_rdata = 8'h99;
        cpu_req = 1; cpu_addr = 13'h055;
        tick();
        chk("t4_addr1", mem_addr, 13'h055);
        cpu_req = 0; cpu_addr = 13'h0AA;
        tick();
        chk("t4_addr2", mem_addr, 13'h055);
        tick();
        chk("t4_ack", cpu_ack, 1);
        chk("t4_rdata", cpu_rdata, 8'h99);
        tick();
        chk("t4_ack_off", cpu_ack, 0);

        // 5: reset during access, then tie goes to CPU
        mem_rdata = 8'h6D;
        dma_req = 1; dma_addr = 13'h100;
        tick();
        chk("t5_rd", {mem_rd, owner}, 2'b11);
        rst_n = 0;
        #1;
        chk("t5_rst_strb", {mem_rd, mem_wr, busy}, 0);
        chk("t5_rst_ack", {cpu_ack, dma_ack, owner}, 0);
        cpu_req = 1; cpu_addr = 13'h033;
        #2 rst_n = 1;
        tick();
        chk("t5_tie_cpu", owner, 0);
        chk("t5_addr", mem_addr, 13'h033);
        tick();
        tick();
        chk("t5_cack", {dma_ack, cpu_ack}, 2'b01);
        chk("t5_crd", cpu_rdata, 8'h6D);
        cpu_req = 0;
        tick();
        tick();
        chk("t5_dma", {owner, mem_rd}, 2'b11);
        chk("t5_daddr", mem_addr, 13'h100);
        tick();
        tick();
        chk("t5_dack", {dma_ack, cpu_ack}, 2'b10);
        chk("t5_drd", dma_rdata, 8'h6D);
        dma_req = 0;
        tick();

        // 6: zero wait-state instance
        rst_n = 0;
        #2 rst_n = 1;
        mem_rdata = 8'h4E;
        cpu_req = 1; cpu_wr = 0; cpu_addr = 13'h0C3;
        tick();
        chk("t6_rd", {z_mem_rd, z_busy}, 2'b11);
        chk("t6_addr", z_mem_addr, 13'h0C3);
        tick();
        chk("t6_rd_off", z_mem_rd, 0);
        chk("t6_ack", z_cpu_ack, 1);
        chk("t6_rdata", z_cpu_rdata, 8'h4E);
        cpu_req = 0;
        tick();
        chk("t6_ack_off", {z_cpu_ack, z_busy}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
